// File: rtl/argmax_stream_64_if.sv
// Stream bundle for argmax_stream_64: the input beat handshake plus the result handshake.
// The slave modport is the reduction block's view of the bundle. The master modport is the view of the producer/consumer side.
interface argmax_stream_64_if #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8
);
    logic                   i_valid;
    logic                   o_ready;
    logic [WIDTH*64-1:0]    i_data;
    logic                   i_last;
    logic                   o_valid;
    logic                   i_ready;
    logic [WIDTH-1:0]       o_max;
    logic [CNT_W+5:0]       o_idx;
    logic [CNT_W:0]         o_beats;
    logic                   o_ovf;

    modport slave (
        input  i_valid, i_data, i_last, i_ready,
        output o_ready, o_valid, o_max, o_idx, o_beats, o_ovf
    );

    modport master (
        output i_valid, i_data, i_last, i_ready,
        input  o_ready, o_valid, o_max, o_idx, o_beats, o_ovf
    );
endinterface

// File: rtl/argmax_stream_64.sv
// Streaming argmax over packets of 64-lane vectors: reports the packet maximum and its {beat, lane} position.
module argmax_stream_64 #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    argmax_stream_64_if.slave  bus
);
    localparam int LANES = 64;

    logic                     ready_en;
    logic [CNT_W-1:0]         beat_cnt;
    logic                     ovf_sticky;

    logic                     a_valid;
    logic                     a_last;
    logic                     a_first;
    logic                     a_ovf;
    logic [CNT_W-1:0]         a_beat;
    logic [WIDTH*LANES-1:0]   a_data;

    logic [WIDTH-1:0]         acc_max;
    logic [CNT_W+5:0]         acc_idx;

    logic [WIDTH-1:0]         beat_max;
    logic [5:0]               beat_lane;
    logic                     take_beat;
    logic [WIDTH-1:0]         merged_max;
    logic [CNT_W+5:0]         merged_idx;

    logic                     a_adv;
    logic                     xfer;
    logic                     merge_en;
    logic                     load_out;

    // The strict compare keeps the lowest lane on ties within a beat.
    always_comb begin
        beat_max  = a_data[WIDTH-1:0];
        beat_lane = '0;
        for (int n = 1; n < LANES; n++) begin
            if (a_data[n*WIDTH +: WIDTH] > beat_max) begin
                beat_max  = a_data[n*WIDTH +: WIDTH];
                beat_lane = 6'(n);
            end
        end
    end

    assign take_beat  = a_first || (beat_max > acc_max);
    assign merged_max = take_beat ? beat_max : acc_max;
    assign merged_idx = take_beat ? {a_beat, beat_lane} : acc_idx;

    // Only a last beat has to wait for the output slot.
    assign a_adv       = !a_last || !bus.o_valid || bus.i_ready;
    assign bus.o_ready = ready_en && (!a_valid || a_adv);
    assign xfer        = bus.i_valid && bus.o_ready;
    assign merge_en    = a_valid && a_adv;
    assign load_out    = a_valid && a_last && a_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en   <= 1'b0;
            beat_cnt   <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (xfer) begin
                if (bus.i_last) begin
                    beat_cnt   <= '0;
                    ovf_sticky <= 1'b0;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                    if (&beat_cnt)
                        ovf_sticky <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_last  <= 1'b0;
            a_first <= 1'b0;
            a_ovf   <= 1'b0;
            a_beat  <= '0;
            a_data  <= '0;
        end else if (bus.o_ready) begin
            a_valid <= bus.i_valid;
            if (bus.i_valid) begin
                a_last  <= bus.i_last;
                a_first <= (beat_cnt == '0);
                a_ovf   <= ovf_sticky;
                a_beat  <= beat_cnt;
                a_data  <= bus.i_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_max <= '0;
            acc_idx <= '0;
        end else if (merge_en) begin
            acc_max <= merged_max;
            acc_idx <= merged_idx;
        end
    end

    // A result loading on the same edge it is consumed keeps o_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_valid <= 1'b0;
            bus.o_max   <= '0;
            bus.o_idx   <= '0;
            bus.o_beats <= '0;
            bus.o_ovf   <= 1'b0;
        end else if (load_out) begin
            bus.o_valid <= 1'b1;
            bus.o_max   <= merged_max;
            bus.o_idx   <= merged_idx;
            bus.o_beats <= (CNT_W+1)'(a_beat) + 1'b1;
            bus.o_ovf   <= a_ovf;
        end else if (bus.o_valid && bus.i_ready) begin
            bus.o_valid <= 1'b0;
        end
    end
endmodule

// File: doc/argmax_stream_64.md
Name: argmax_stream_64

Overview:
- Streaming reduction block for the pooling/classifier output path. Consumes a packet of one or more 64-lane vectors over a valid/ready handshake.
- Returns, per packet, the maximum element value and its global position: beat number × 64 + lane.
- Used downstream of the max-pool datapath where the winning position is needed, not only the value, e.g. classification argmax and unpooling index capture.

Parameters:
- WIDTH, 6, bit width of each unsigned lane element.
- CNT_W, 8, beat-counter width; maximum legal packet length is 2^CNT_W beats.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active low.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept an input beat.
- i_data  in  WIDTH*64  64 lanes; lane n is i_data[n*WIDTH +: WIDTH].
- i_last  in  1  final beat of the packet.
- o_valid  out  1  packet result valid.
- i_ready  in  1  downstream accepts the result.
- o_max  out  WIDTH  packet maximum value.
- o_idx  out  CNT_W+6  global index of the maximum: {beat, lane}.
- o_beats  out  CNT_W+1  number of beats in the packet.
- o_ovf  out  1  packet exceeded 2^CNT_W beats.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset state: o_valid=0, o_max=0, o_idx=0, o_beats=0, o_ovf=0, all internal valid flags=0, beat counter=0. o_ready=1 one cycle after rst_n deasserts.
- Input handshake: a beat transfers on a rising edge with i_valid&&o_ready. The sender must hold i_data and i_last stable while i_valid=1 and o_ready=0.
- Stage A (input register): a transferred beat is captured together with i_last, the current beat number and a "first" flag (beat number == 0).
- Stage B (merge): combinationally, compute the per-beat maximum of the stage-A data and its lowest lane index. Merge into the accumulator:
  - First beat of a packet: replace the accumulator unconditionally.
  - Otherwise: replace only if the beat maximum is strictly greater than the stored maximum.
  - Tie rule: on equal values, the lowest global index wins, within a beat and across beats.
- Beat counter: increments on each transfer and clears to 0 on a transfer with i_last=1.
  - Wraps modulo 2^CNT_W.
  - A wrap without i_last sets a sticky packet-overflow bit, reported in o_ovf for that packet.
- Output: when stage A holds the last beat and advances, the merged result loads into the output register and o_valid=1.
  - o_max, o_idx, o_beats and o_ovf are held stable until o_valid&&i_ready.
  - o_valid clears on that edge unless a new result loads on the same edge.
- Latency: last-beat transfer at edge k gives o_valid=1 from edge k+1. A single-beat packet has the same latency.
- Stage A advances when it is empty or holds a non-last beat, or when the output slot is free: !o_valid || i_ready.
- o_ready = !stageA_valid || stageA_advance. This gives full throughput of one beat per cycle when the downstream is not stalled.
- Back-to-back packets: a new packet's first beat may transfer on the same edge the previous last beat merges. The accumulators do not interfere because of the first-flag replace rule.
- Output stall: while o_valid=1 and i_ready=0, a last beat in stage A stalls and o_ready drops. Non-last beats continue to merge until the next last beat reaches stage A.
- Reset mid-packet discards the partial packet and any unread result.
- Arithmetic: unsigned compares only. o_idx = {beat[CNT_W-1:0], lane[5:0]}. o_beats = beat count, where the value 2^CNT_W is representable.

Test Plan:
- Single beat, lane 37 = 0x3F, all others 0x05, i_last=1 -> o_max=0x3F, o_idx=37, o_beats=1, o_valid one edge after transfer.
- 3-beat packet, beat maxima 10, 40, 40 (lanes 2, 9, 1) -> o_max=40, o_idx=73 (beat 1 lane 9), o_beats=3; later equal value does not replace.
- All lanes equal 0x11 in a 2-beat packet -> o_idx=0, o_max=0x11.
- Back-to-back 1-beat packets every cycle with i_ready=1 -> o_ready stays 1, one result per cycle in order.
- i_ready=0 for 5 cycles with two packets queued -> first result held stable, o_ready=0 while stage A holds a last beat, no loss; release yields both results in order.
- rst_n pulsed low after 2 beats of a 4-beat packet -> o_valid=0, outputs 0; the next packet reports o_beats counted from 0.
